bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 91 +++++++++
 tb/tb_bit_serializer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter: each bit is presented for one SETUP cycle,
// strobed high for one cycle and held for one cycle after the SCK falling edge.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             CK,
    input  logic             RSTn,
    input  logic [WIDTH-1:0] DIN,
    input  logic             VALID,
    output logic             READY,
    output logic             D,
    output logic             SCK,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        HOLD
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shnext;
    logic [CW-1:0]    cnt;

    assign READY = (state == IDLE);

    // The bit to transmit always sits at the leading end of the shift register.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    always_comb begin
        shnext = shreg;
        if (MSB_FIRST) shnext = {shreg[WIDTH-2:0], 1'b0};
        else           shnext = {1'b0, shreg[WIDTH-1:1]};
    end

    always_ff @(posedge CK) begin
        if (!RSTn) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            D     <= 1'b0;
            SCK   <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (VALID) begin
                        shreg <= DIN;
                        cnt   <= '0;
                        D     <= lead_bit(DIN);
                        BUSY  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    SCK   <= 1'b1;
                    state <= HIGH;
                end
                HIGH: begin
                    SCK   <= 1'b0;
                    state <= HOLD;
                end
                HOLD: begin
                    if (cnt < CW'(WIDTH - 1)) begin
                        shreg <= shnext;
                        D     <= lead_bit(shnext);
                        cnt   <= cnt + CW'(1);
                        state <= SETUP;
                    end else begin
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: three instances (8-bit MSB-first,
// 8-bit LSB-first, 5-bit MSB-first) with falling-SCK receiver models.
module tb_bit_serializer;

    logic       CK = 1'b0;
    logic       RSTn;
    logic [7:0] din;
    logic       v_m, v_l, v_5;
    logic       rdy_m, d_m, sck_m, busy_m, done_m;
    logic       rdy_l, d_l, sck_l, busy_l, done_l;
    logic       rdy_5, d_5, sck_5, busy_5, done_5;

    int checks = 0;
    int errors = 0;

    bit cap_m[$];
    bit cap_l[$];
    bit cap_5[$];

    always #5 CK = ~CK;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
        .CK(CK), .RSTn(RSTn), .DIN(din), .VALID(v_m), .READY(rdy_m),
        .D(d_m), .SCK(sck_m), .BUSY(busy_m), .DONE(done_m));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (
        .CK(CK), .RSTn(RSTn), .DIN(din), .VALID(v_l), .READY(rdy_l),
        .D(d_l), .SCK(sck_l), .BUSY(busy_l), .DONE(done_l));

    bit_serializer #(.WIDTH(5), .MSB_FIRST(1'b1)) u_5 (
        .CK(CK), .RSTn(RSTn), .DIN(din[4:0]), .VALID(v_5), .READY(rdy_5),
        .D(d_5), .SCK(sck_5), .BUSY(busy_5), .DONE(done_5));

    // Receivers: capture D on each SCK falling edge outside reset.
    always @(negedge sck_m) if (RSTn) cap_m.push_back(d_m);
    always @(negedge sck_l) if (RSTn) cap_l.push_back(d_l);
    always @(negedge sck_5) if (RSTn) cap_5.push_back(d_5);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CK);
    endtask

    function automatic int width_of(input int sel);
        return (sel == 2) ? 5 : 8;
    endfunction

    function automatic bit msb_of(input int sel);
        return sel != 1;
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done_m;
            1:       return done_l;
            default: return done_5;
        endcase
    endfunction

    // Bit transmitted in position i of word w.
    function automatic logic exp_bit(input logic [7:0] w, input int i, input int width, input bit msb);
        return msb ? w[width-1-i] : w[i];
    endfunction

    task automatic set_valid(input int sel, input logic v);
        case (sel)
            0:       v_m = v;
            1:       v_l = v;
            default: v_5 = v;
        endcase
    endtask

    task automatic clear_cap(input int sel);
        case (sel)
            0:       cap_m.delete();
            1:       cap_l.delete();
            default: cap_5.delete();
        endcase
    endtask

    // Rebuild the received word from the capture queue and compare with w.
    task automatic check_cap(input string tag, input int sel, input logic [7:0] w);
        bit         q[$];
        logic [7:0] word;
        int         wd;
        wd = width_of(sel);
        case (sel)
            0:       q = cap_m;
            1:       q = cap_l;
            default: q = cap_5;
        endcase
        chk({tag, "_nbits"}, 32'(q.size()), 32'(wd));
        word = '0;
        for (int i = 0; i < q.size() && i < wd; i++)
            word[msb_of(sel) ? (wd - 1 - i) : i] = q[i];
        chk({tag, "_word"}, 32'(word), 32'(w & 8'((1 << wd) - 1)));
    endtask

    task automatic wait_done(input string tag, input int sel);
        int n;
        n = 0;
        while (!done_of(sel) && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_of(sel)), 32'd1);
    endtask

    task automatic run_word(input string tag, input int sel, input logic [7:0] w);
        clear_cap(sel);
        din = w;
        set_valid(sel, 1'b1);
        tick();
        set_valid(sel, 1'b0);
        din = 8'($urandom);
        wait_done(tag, sel);
        check_cap(tag, sel, w);
    endtask

    initial begin
        logic es, eb, ed;
        RSTn = 1'b0;
        din  = 8'hFF;
        v_m  = 1'b1;
        v_l  = 1'b1;
        v_5  = 1'b1;

        // Reset held with a handshake offered: outputs idle, handshake discarded.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_m", 32'({rdy_m, busy_m, sck_m, d_m, done_m}), 32'b10000);
            chk("rst_l", 32'({rdy_l, busy_l, sck_l, d_l, done_l}), 32'b10000);
            chk("rst_5", 32'({rdy_5, busy_5, sck_5, d_5, done_5}), 32'b10000);
        end
        RSTn = 1'b1;
        v_m  = 1'b0;
        v_l  = 1'b0;
        v_5  = 1'b0;

        // No VALID for 20 cycles: everything stays idle.
        for (int i = 0; i < 20; i++) begin
            din = 8'($urandom);
            tick();
            chk("idle_m", 32'({rdy_m, busy_m, sck_m, d_m, done_m}), 32'b10000);
            chk("idle_5", 32'({rdy_5, busy_5, sck_5, d_5, done_5}), 32'b10000);
        end

        // 8'hC4 into both 8-bit instances at edge 0; cycle-exact waveform check.
        cap_m.delete();
        cap_l.delete();
        din = 8'hC4;
        v_m = 1'b1;
        v_l = 1'b1;
        tick();
        v_m = 1'b0;
        v_l = 1'b0;
        din = 8'h3B;
        for (int c = 1; c <= 26; c++) begin
            int bi;
            es = (c % 3 == 2) && (c <= 23);
            eb = (c <= 24);
            ed = (c == 25);
            bi = (c <= 24) ? (c - 1) / 3 : 7;
            chk("wave_m", 32'({sck_m, busy_m, done_m, rdy_m, d_m}),
                32'({es, eb, ed, ~eb, exp_bit(8'hC4, bi, 8, 1'b1)}));
            chk("wave_l", 32'({sck_l, busy_l, done_l, rdy_l, d_l}),
                32'({es, eb, ed, ~eb, exp_bit(8'hC4, bi, 8, 1'b0)}));
            if (c < 26) tick();
        end
        check_cap("c4_m", 0, 8'hC4);
        check_cap("c4_l", 1, 8'hC4);

        // VALID held: second word accepted in the DONE cycle; DIN churn ignored.
        cap_m.delete();
        din = 8'hFF;
        v_m = 1'b1;
        tick();
        for (int c = 1; c <= 24; c++) begin
            din = (c == 24) ? 8'h00 : 8'($urandom);
            tick();
        end
        chk("b2b_done25", 32'({done_m, rdy_m}), 32'b11);
        tick();
        v_m = 1'b0;
        chk("b2b_setup26", 32'({busy_m, sck_m, rdy_m, d_m}), 32'b1000);
        check_cap("b2b_first", 0, 8'hFF);
        cap_m.delete();
        wait_done("b2b_second", 0);
        check_cap("b2b_second", 0, 8'h00);

        // Reset during the HIGH of bit 3 (cycle 11) aborts without DONE.
        cap_m.delete();
        din = 8'h96;
        v_m = 1'b1;
        tick();
        v_m = 1'b0;
        for (int c = 1; c < 11; c++) tick();
        chk("abort_high", 32'({sck_m, busy_m}), 32'b11);
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        chk("abort_idle", 32'({rdy_m, busy_m, sck_m, d_m, done_m}), 32'b10000);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_nodone", 32'({done_m, busy_m, sck_m}), 32'b000);
        end
        run_word("after_abort", 0, 8'hA5);

        // Random words through every instance.
        for (int i = 0; i < 16; i++) run_word("rnd_m", 0, 8'($urandom));
        for (int i = 0; i < 16; i++) run_word("rnd_l", 1, 8'($urandom));
        for (int i = 0; i < 16; i++) run_word("rnd_5", 2, 8'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
